// File: rtl/load_store_unit_if.sv
// memory_bus: single-outstanding request channel between a CPU-side consumer
// (load_store_unit) and memory_system.
//   addr           byte address of the access
//   write_data     store data, already masked to mem_width
//   dispatch_read  one-cycle read request pulse
//   dispatch_write one-cycle write request pulse
//   mem_width      0 = BYTE, 1 = WORD (16 bit), 2 = DWORD (32 bit)
//   read_data      load data; valid in the cycle busy is low
//   busy           memory_system is processing an access
interface memory_bus;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [1:0]  mem_width;
    logic [31:0] read_data;
    logic        busy;

    modport CONSUMER (
        output addr,
        output write_data,
        output dispatch_read,
        output dispatch_write,
        output mem_width,
        input  read_data,
        input  busy
    );

    modport PROVIDER (
        input  addr,
        input  write_data,
        input  dispatch_read,
        input  dispatch_write,
        input  mem_width,
        output read_data,
        output busy
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: executes one RV32I load/store per request handshake.
// Checks funct3 legality and alignment at accept, issues a single dispatch
// pulse on memory_bus, waits for busy to drop (with timeout), then masks and
// sign/zero-extends the read data and returns a buffered response.
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   req_*                 request channel (valid/ready), funct3, addr, wdata, rd
//   resp_*                response channel (valid/ready), data, rd tag, cause
//                         cause: 0 ok, 1 misaligned, 2 illegal funct3, 3 timeout
//   bus                   memory_bus consumer side
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_cause,
    memory_bus.CONSUMER bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] WidthByte  = 2'd0;
    localparam logic [1:0] WidthWord  = 2'd1;
    localparam logic [1:0] WidthDword = 2'd2;

    localparam logic [1:0] CauseOk         = 2'd0;
    localparam logic [1:0] CauseMisaligned = 2'd1;
    localparam logic [1:0] CauseIllegal    = 2'd2;
    localparam logic [1:0] CauseTimeout    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      width_q, width_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic [1:0]      resp_cause_q, resp_cause_d;

    logic        acc_illegal;
    logic        acc_misaligned;
    logic [31:0] acc_wdata;
    logic [1:0]  acc_width;
    logic [31:0] load_ext;

    // Request decode, evaluated on the live request fields at accept time.
    always_comb begin
        if (req_is_store) begin
            acc_illegal = (req_funct3 >= 3'd3);
        end else begin
            acc_illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        end

        unique case (req_funct3[1:0])
            2'd1:    acc_misaligned = req_addr[0];
            2'd2:    acc_misaligned = |req_addr[1:0];
            default: acc_misaligned = 1'b0;
        endcase

        unique case (req_funct3[1:0])
            2'd0: begin
                acc_wdata = {24'd0, req_wdata[7:0]};
                acc_width = WidthByte;
            end
            2'd1: begin
                acc_wdata = {16'd0, req_wdata[15:0]};
                acc_width = WidthWord;
            end
            default: begin
                acc_wdata = req_wdata;
                acc_width = WidthDword;
            end
        endcase
    end

    // Narrow reads come back with garbage upper bits, so always mask.
    always_comb begin
        unique case (funct3_q)
            3'd0:    load_ext = {{24{bus.read_data[7]}}, bus.read_data[7:0]};
            3'd4:    load_ext = {24'd0, bus.read_data[7:0]};
            3'd1:    load_ext = {{16{bus.read_data[15]}}, bus.read_data[15:0]};
            3'd5:    load_ext = {16'd0, bus.read_data[15:0]};
            default: load_ext = bus.read_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        width_d      = width_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_cause_d = resp_cause_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    resp_rd_d   = req_rd;
                    resp_data_d = 32'd0;
                    if (acc_illegal) begin
                        resp_cause_d = CauseIllegal;
                        state_d      = StResp;
                    end else if (acc_misaligned) begin
                        resp_cause_d = CauseMisaligned;
                        state_d      = StResp;
                    end else begin
                        // Bus-facing latches only move when an access is made.
                        addr_d       = req_addr;
                        wdata_d      = acc_wdata;
                        width_d      = acc_width;
                        is_store_d   = req_is_store;
                        funct3_d     = req_funct3;
                        resp_cause_d = CauseOk;
                        state_d      = StDispatch;
                    end
                end
            end
            StDispatch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (!bus.busy) begin
                    resp_data_d  = is_store_q ? 32'd0 : load_ext;
                    resp_cause_d = CauseOk;
                    state_d      = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d  = 32'd0;
                    resp_cause_d = CauseTimeout;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            width_q      <= WidthByte;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            cnt_q        <= '0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_cause_q <= CauseOk;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            width_q      <= width_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    // Never accept while memory_system is still finishing an earlier access.
    assign req_ready  = (state_q == StIdle) && !bus.busy;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_cause = resp_cause_q;

    assign bus.dispatch_read  = (state_q == StDispatch) && !is_store_q;
    assign bus.dispatch_write = (state_q == StDispatch) && is_store_q;
    assign bus.addr           = addr_q;
    assign bus.write_data     = wdata_q;
    assign bus.mem_width      = width_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side consumer of memory_bus; sits between the core's execute/writeback stages and memory_system.
- Accepts one RV32I load/store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW) and checks alignment and funct3.
- Issues a single dispatch pulse on memory_bus, waits on busy, and masks and sign-extends read_data.
- Returns a buffered response with rd tag and fault cause to writeback.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles with bus.busy high before a timeout fault; range 2..65535.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 of the load/store.
- req_addr  input  32  effective byte address.
- req_wdata  input  32  store data (rs2).
- req_rd  input  5  destination register tag.
- resp_valid  output  1  response present.
- resp_ready  input  1  writeback accepts response.
- resp_data  output  32  extended load data; 0 for stores and faults.
- resp_rd  output  5  latched req_rd.
- resp_cause  output  2  0 ok, 1 misaligned, 2 illegal funct3, 3 timeout.
- bus  modport  memory_bus.CONSUMER  addr, write_data, dispatch_read, dispatch_write, mem_width out; read_data, busy in.

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE; resp_valid=0; resp_data=0; resp_rd=0; resp_cause=0.
  - bus.dispatch_read=bus.dispatch_write=0; bus.addr=0; bus.write_data=0; bus.mem_width=BYTE.
  - Reset mid-transaction abandons it; no response is produced.
- States: IDLE, DISPATCH, WAIT, RESP.
- req_ready = (state==IDLE) && !bus.busy. The unit never accepts while memory_system is still busy, including after a timeout or reset.
- IDLE, on req_valid&&req_ready:
  - Latch addr, rd, is_store, funct3.
  - Latch write_data masked to width: SB keeps [7:0], SH keeps [15:0], SW keeps all; upper bits zero.
  - mem_width: funct3[1:0] 0→BYTE, 1→WORD, 2→DWORD.
- Fault checks at accept (no bus access is made on a fault):
  - Illegal funct3: loads 3/6/7; stores ≥3 → cause 2.
  - Misaligned: halfword with addr[0]≠0, or word with addr[1:0]≠0 → cause 1.
  - Illegal check takes priority over misaligned.
  - On fault: go to RESP next cycle with resp_data=0.
  - No fault: go to DISPATCH.
- DISPATCH (exactly 1 cycle):
  - dispatch_read=!is_store, dispatch_write=is_store; decoded from state, combinational.
  - addr, write_data, mem_width driven from latches and held stable through WAIT.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If !bus.busy: capture bus.read_data (valid in the same cycle busy is low), then extend per funct3:
    - 0: sign-extend [7:0]
    - 4: zero-extend [7:0]
    - 1: sign-extend [15:0]
    - 5: zero-extend [15:0]
    - 2: pass [31:0]
  - Upper bits of read_data are garbage for narrow reads (the ROM path is unmasked), so masking is mandatory.
  - Stores produce resp_data=0. Cause 0; go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: cause 3, resp_data=0, go to RESP.
  - busy low on the first WAIT cycle is legal (FB/IO writes complete immediately).
- RESP:
  - resp_valid=1; data, rd and cause held stable until resp_ready.
  - On resp_ready go to IDLE. No new request is accepted in the same cycle (req_ready is low in RESP).
- Latency (load, no backpressure): accept at cycle 0, dispatch at cycle 1, then WAIT until busy drops. resp_valid rises on the cycle after busy is seen low.
- Fault latency: resp_valid at cycle 1.
- bus.addr[31:30] is passed through unchecked.
- Counter width is clog2(TIMEOUT_CYCLES)+1; it does not wrap before the compare.

Test Plan:
- LB at 0x1000_0004, model returns 0x0000_0080 after 3 busy cycles → dispatch_read for 1 cycle, mem_width=BYTE, resp_data=0xFFFF_FF80, cause 0. Repeat as LBU → 0x0000_0080.
- LH at 0x0000_0102 (ROM), read_data=0xAABB_8012 → resp_data=0xFFFF_8012. LHU → 0x0000_8012.
- LW at 0x1000_0001 → cause 1 at cycle 1, zero dispatch pulses on the bus. Load funct3=3 at 0x1000_0001 → cause 2.
- SW 0xDEAD_BEEF to 0x2000_0010, busy low immediately after dispatch → write_data=0xDEAD_BEEF, mem_width=DWORD, one dispatch_write pulse, resp_valid cycle 3. SB with req_wdata 0x1234_56AB → write_data=0x0000_00AB.
- Bus busy stuck high → cause 3 after exactly 255 WAIT cycles. req_ready stays 0 until busy drops.
- resp_ready held low 10 cycles → resp fields stable, req_ready=0. Assert rst_n_in low mid-WAIT → outputs reach reset values without a clock edge, and no response follows.
